// File: rtl/bus_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin bus scheduler.
package bus_sched_pkg;

    typedef enum logic [1:0] {IDLE, POP, DECODE, DELIVER} state_e;

    localparam int HDR_W     = 8;
    localparam int MAX_PKT_W = 64;

    // Destination ID sits in the top HDR_W bits of a pkt_w-wide packet.
    function automatic logic [HDR_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                                 input int pkt_w);
        return pkt[pkt_w-1 -: HDR_W];
    endfunction

endpackage

// File: rtl/bus_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt_id,
    output logic          any
);

    logic [2*N-1:0] dbl;
    logic [PW:0]    idx;

    assign dbl = {req, req};

    // Scan downwards so the closest request after ptr is the last one written.
    always_comb begin
        gnt_id = '0;
        any    = |req;
        idx    = '0;
        for (int k = N; k >= 1; k--) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (dbl[idx]) begin
                gnt_id = (idx >= (PW+1)'(N)) ? PW'(idx - (PW+1)'(N)) : PW'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler moving packets from driver FIFOs to monitor FIFOs
// over a shared bus, with unicast, broadcast and invalid-destination drop.
module bus_rr_scheduler
    import bus_sched_pkg::*;
#(
    parameter int          drvrs     = 4,
    parameter int          pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF,
    parameter int          cnt_w     = 16,
    localparam int         GW        = $clog2(drvrs)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [drvrs-1:0]         pndng,
    input  logic [drvrs*pckg_sz-1:0] D_pop,
    input  logic [drvrs-1:0]         full,
    output logic [drvrs-1:0]         pop,
    output logic [drvrs-1:0]         push,
    output logic [pckg_sz-1:0]       D_push,
    output logic [GW-1:0]            grant_id,
    output logic                     busy,
    output logic                     drop,
    output logic [cnt_w-1:0]         pkt_cnt
);

    state_e             state_q;
    logic [GW-1:0]      grant_q;
    logic [GW-1:0]      rr_ptr_q;
    logic [pckg_sz-1:0] pkt_q;
    logic [pckg_sz-1:0] dpush_q;
    logic [drvrs-1:0]   mask_q;
    logic [drvrs-1:0]   pop_q;
    logic               drop_q;
    logic [cnt_w-1:0]   cnt_q;

    logic [GW-1:0]      pick_id;
    logic               pick_any;
    logic [pckg_sz-1:0] head;
    logic [HDR_W-1:0]   head_dest;
    logic [drvrs-1:0]   mask_d;
    logic               drop_d;
    logic               deliver_ok;

    rr_pick #(.N(drvrs), .PW(GW)) u_pick (
        .req    (pndng),
        .ptr    (rr_ptr_q),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    // Destination is resolved while popping so drop can pulse during DECODE.
    always_comb begin
        head = '0;
        for (int i = 0; i < drvrs; i++) begin
            if (grant_q == GW'(i)) head = D_pop[i*pckg_sz +: pckg_sz];
        end
        head_dest = dest_of(MAX_PKT_W'(head), pckg_sz);
        mask_d    = '0;
        drop_d    = 1'b0;
        if (head_dest == broadcast) begin
            mask_d          = '1;
            mask_d[grant_q] = 1'b0;
        end else if (head_dest < HDR_W'(drvrs)) begin
            mask_d[head_dest[GW-1:0]] = 1'b1;
        end else begin
            drop_d = 1'b1;
        end
    end

    assign deliver_ok = (state_q == DELIVER) && ((mask_q & full) == '0);
    assign push       = deliver_ok ? mask_q : '0;
    assign D_push     = deliver_ok ? pkt_q : dpush_q;
    assign pop        = pop_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q != IDLE);
    assign drop       = drop_q;
    assign pkt_cnt    = cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= GW'(drvrs - 1);
            pkt_q    <= '0;
            dpush_q  <= '0;
            mask_q   <= '0;
            pop_q    <= '0;
            drop_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pop_q  <= '0;
            drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q        <= pick_id;
                        pop_q[pick_id] <= 1'b1;
                        state_q        <= POP;
                    end
                end
                POP: begin
                    pkt_q   <= head;
                    mask_q  <= mask_d;
                    drop_q  <= drop_d;
                    state_q <= DECODE;
                end
                DECODE: begin
                    if (drop_q) begin
                        rr_ptr_q <= grant_q;
                        state_q  <= IDLE;
                    end else begin
                        state_q  <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (deliver_ok) begin
                        dpush_q  <= pkt_q;
                        cnt_q    <= cnt_q + cnt_w'(1);
                        rr_ptr_q <= grant_q;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed bench for bus_rr_scheduler; pushes are checked against a scoreboard
// queue filled when each packet is offered.
module tb_bus_rr_scheduler;

    typedef struct packed {
        logic [3:0]  mask;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  pndng;
    logic [63:0] dPop;
    logic [3:0]  full;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [15:0] dPush;
    logic [1:0]  grantId;
    logic        busy;
    logic        drop;
    logic [15:0] pktCnt;

    int   nChecks = 0;
    int   nFails  = 0;
    int   pushCount = 0;
    int   expCnt = 0;
    exp_t sbQ[$];

    bus_rr_scheduler dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (dPop),
        .full     (full),
        .pop      (pop),
        .push     (push),
        .D_push   (dPush),
        .grant_id (grantId),
        .busy     (busy),
        .drop     (drop),
        .pkt_cnt  (pktCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mkExp(input logic [3:0] m, input logic [15:0] d);
        exp_t e;
        e.mask = m;
        e.data = d;
        return e;
    endfunction

    // Every push seen on the bus must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && push !== 4'b0000) begin
                pushCount++;
                if (sbQ.size() == 0) begin
                    checkOutput("sb_unexpected_push", 32'(push), 32'(0));
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("sb_push_mask", 32'(push), 32'(e.mask));
                    checkOutput("sb_push_data", 32'(dPush), 32'(e.data));
                end
            end
        end
    end

    // Offer one packet from src at the next edge, then check the pop pulse.
    task automatic applyStimulus(input int src, input logic [15:0] pkt,
                                 input bit deliver, input logic [3:0] expMask);
        @(negedge clk);
        dPop[src*16 +: 16] = pkt;
        pndng = 4'(1 << src);
        if (deliver) begin
            sbQ.push_back(mkExp(expMask, pkt));
            expCnt++;
        end
        @(posedge clk);
        #1 pndng = 4'b0000;
        @(negedge clk);
        checkOutput("issue_pop", 32'(pop), 32'(1 << src));
        checkOutput("issue_grant", 32'(grantId), 32'(src));
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_idle_timeout"}, 32'(n < 50), 32'(1));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pop"},   32'(pop),     32'(0));
        checkOutput({tag, "_push"},  32'(push),    32'(0));
        checkOutput({tag, "_dpush"}, 32'(dPush),   32'(0));
        checkOutput({tag, "_grant"}, 32'(grantId), 32'(0));
        checkOutput({tag, "_busy"},  32'(busy),    32'(0));
        checkOutput({tag, "_drop"},  32'(drop),    32'(0));
        checkOutput({tag, "_cnt"},   32'(pktCnt),  32'(0));
    endtask

    initial begin
        int order[5];
        int nPops;
        int pushBase;

        reset = 1'b0;
        pndng = 4'b0000;
        dPop  = '0;
        full  = 4'b0000;
        #3 checkAllZero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Unicast 0 -> 2 with the exact cycle-by-cycle latency.
        applyStimulus(0, 16'h0211, 1'b1, 4'b0100);
        checkOutput("uni_busy_pop", 32'(busy), 32'(1));
        @(negedge clk);
        checkOutput("uni_pop_pulse_off", 32'(pop), 32'(0));
        @(negedge clk);
        checkOutput("uni_push", 32'(push), 32'(4'b0100));
        checkOutput("uni_dpush", 32'(dPush), 32'(16'h0211));
        @(negedge clk);
        checkOutput("uni_push_off", 32'(push), 32'(0));
        checkOutput("uni_dpush_hold", 32'(dPush), 32'(16'h0211));
        checkOutput("uni_cnt", 32'(pktCnt), 32'(expCnt));
        checkOutput("uni_grant", 32'(grantId), 32'(0));
        checkOutput("uni_idle", 32'(busy), 32'(0));

        // Broadcast from driver 2 reaches everyone but the source, once.
        pushBase = pushCount;
        applyStimulus(2, 16'hFFAB, 1'b1, 4'b1011);
        waitIdle("bcast");
        checkOutput("bcast_single_pulse", 32'(pushCount - pushBase), 32'(1));
        checkOutput("bcast_cnt", 32'(pktCnt), 32'(expCnt));

        // Reset again so port 0 leads the fairness rotation.
        @(negedge clk);
        reset = 1'b0;
        #1 checkAllZero("reset2");
        @(negedge clk);
        reset = 1'b1;
        expCnt = 0;

        // All four drivers pending for 20 cycles, all addressed to port 0.
        dPop = {16'h0043, 16'h0032, 16'h0021, 16'h0010};
        sbQ.push_back(mkExp(4'b0001, 16'h0010));
        sbQ.push_back(mkExp(4'b0001, 16'h0021));
        sbQ.push_back(mkExp(4'b0001, 16'h0032));
        sbQ.push_back(mkExp(4'b0001, 16'h0043));
        sbQ.push_back(mkExp(4'b0001, 16'h0010));
        expCnt += 5;
        nPops = 0;
        pndng = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pop !== 4'b0000) begin
                checkOutput("fair_pop_onehot", 32'(pop), 32'(1 << grantId));
                if (nPops < 5) order[nPops] = int'(grantId);
                nPops++;
            end
        end
        pndng = 4'b0000;
        checkOutput("fair_pop_count", 32'(nPops), 32'(5));
        checkOutput("fair_order0", 32'(order[0]), 32'(0));
        checkOutput("fair_order1", 32'(order[1]), 32'(1));
        checkOutput("fair_order2", 32'(order[2]), 32'(2));
        checkOutput("fair_order3", 32'(order[3]), 32'(3));
        checkOutput("fair_order4", 32'(order[4]), 32'(0));
        waitIdle("fair");
        checkOutput("fair_cnt", 32'(pktCnt), 32'(expCnt));

        // Driver 1 -> port 3 while port 3 is full for 10 cycles.
        full = 4'b1000;
        applyStimulus(1, 16'h035A, 1'b1, 4'b1000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_busy", 32'(busy), 32'(1));
            checkOutput("bp_no_push", 32'(push), 32'(0));
        end
        @(posedge clk);
        #1 full = 4'b0000;
        @(negedge clk);
        checkOutput("bp_push", 32'(push), 32'(4'b1000));
        checkOutput("bp_dpush", 32'(dPush), 32'(16'h035A));
        waitIdle("bp");
        checkOutput("bp_cnt", 32'(pktCnt), 32'(expCnt));

        // Destination 7 does not exist with four ports.
        pushBase = pushCount;
        applyStimulus(3, 16'h07CC, 1'b0, 4'b0000);
        @(negedge clk);
        checkOutput("inv_drop", 32'(drop), 32'(1));
        @(negedge clk);
        checkOutput("inv_drop_off", 32'(drop), 32'(0));
        checkOutput("inv_idle", 32'(busy), 32'(0));
        checkOutput("inv_cnt", 32'(pktCnt), 32'(expCnt));
        checkOutput("inv_no_push", 32'(pushCount - pushBase), 32'(0));

        // Reset while stuck in DELIVER; the held packet is lost.
        full = 4'b0001;
        applyStimulus(2, 16'h0077, 1'b0, 4'b0000);
        repeat (4) @(negedge clk);
        checkOutput("rst_mid_busy", 32'(busy), 32'(1));
        #2 reset = 1'b0;
        #1 checkAllZero("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        full  = 4'b0000;
        expCnt = 0;
        @(negedge clk);
        dPop[15:0]  = 16'h0199;
        dPop[47:32] = 16'h0077;
        pndng = 4'b0101;
        sbQ.push_back(mkExp(4'b0010, 16'h0199));
        expCnt++;
        @(posedge clk);
        #1 pndng = 4'b0000;
        @(negedge clk);
        checkOutput("rst_first_grant", 32'(grantId), 32'(0));
        checkOutput("rst_first_pop", 32'(pop), 32'(4'b0001));
        waitIdle("rst");
        checkOutput("rst_cnt", 32'(pktCnt), 32'(expCnt));

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", 32'(sbQ.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/bus_rr_scheduler.md
Name: bus_rr_scheduler

Overview:
- Round-robin scheduler for the shared bus between `drvrs` driver/monitor ports.
- Each cycle it considers pending driver FIFOs and grants one requester.
- It pops that requester's head packet, decodes the destination ID in the packet header, and pushes the packet to the target monitor(s).
- Broadcast ID delivers to every port except the source. The block sits between the per-driver FIFOs and the per-monitor receive FIFOs on the bus interface.

Parameters:
- drvrs, 4, number of driver/monitor ports (2..16).
- pckg_sz, 16, packet width in bits; header occupies the top 8 bits.
- broadcast, 8'hFF, destination ID meaning "all ports except source".
- cnt_w, 16, width of delivered-packet counter.

Ports:
- clk  in  1  bus clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pndng  in  drvrs  bit i high: driver FIFO i holds at least one packet.
- D_pop  in  drvrs*pckg_sz  head packet of each driver FIFO; slice i = bits [i*pckg_sz +: pckg_sz].
- full  in  drvrs  bit i high: monitor FIFO i cannot accept a push.
- pop  out  drvrs  one-hot 1-cycle pulse; removes head of granted driver FIFO.
- push  out  drvrs  1-cycle push strobes to monitor FIFOs (one-hot or broadcast mask).
- D_push  out  pckg_sz  shared bus data; valid when any push bit is high.
- grant_id  out  $clog2(drvrs)  current or last granted source.
- busy  out  1  high in every state except IDLE.
- drop  out  1  1-cycle pulse: packet discarded for invalid destination.
- pkt_cnt  out  cnt_w  packets delivered (a broadcast counts once); wraps modulo 2^cnt_w.

Behaviour:
- Reset (reset low, async): all outputs 0; state=IDLE; rr_ptr=drvrs-1, so port 0 has first priority.
- FSM states:
  - IDLE: if pndng != 0, select first set bit scanning rr_ptr+1, rr_ptr+2, … modulo drvrs; store it as grant_id; go POP. Otherwise stay.
  - POP: pop[grant_id]=1 for exactly this cycle; latch D_pop slice grant_id into pkt_r; go DECODE.
  - DECODE: dest=pkt_r[pckg_sz-1 -: 8].
    - dest==broadcast: mask = all ones except bit grant_id.
    - dest<drvrs: mask = one-hot(dest). Self-addressed packets are legal.
    - Otherwise: drop=1 for one cycle, rr_ptr<=grant_id, go IDLE.
    - Valid dest: go DELIVER.
  - DELIVER: wait while (mask & full) != 0. When clear: push=mask and D_push=pkt_r for one cycle; pkt_cnt++; rr_ptr<=grant_id; go IDLE.
- Latency: pndng seen in cycle N → pop in N+1 → push earliest in N+3. Peak throughput is 1 packet per 4 cycles.
- D_push holds pkt_r after a push until the next push. It reads 0 only after reset.
- pndng dropping while in POP: still pop and deliver; the FIFO guarantees head validity when sampled.
- New pndng bits during POP/DECODE/DELIVER are ignored until IDLE.
- full wait is unbounded, with no timeout. Other requesters wait (head-of-line blocking is intended).
- Single requester re-granted back-to-back is legal when no other pndng is set.
- pkt_cnt wraps from 2^cnt_w-1 to 0 with no flag.
- Reset asserted mid-transaction aborts immediately. A popped-but-undelivered packet is lost, which is acceptable.

Decomposition:
- Package bus_sched_pkg:
  - state enum {IDLE, POP, DECODE, DELIVER};
  - localparam HDR_W=8;
  - function dest_of(pkt).
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req[drvrs], ptr.
  - Outputs: gnt_id, any.
  - Implemented as a doubled-vector mask scan; instantiated once.
- Remaining FSM, registers and mask logic live in bus_rr_scheduler.

Test Plan:
- Single unicast:
  - Stimulus: reset release; pndng=4'b0001; D_pop slice0=16'h0211.
  - Expect pop=0001 at N+1; push=0100 with D_push=16'h0211 at N+3; pkt_cnt=1; grant_id=0.
- Broadcast:
  - Stimulus: driver 2 head=16'hFFAB.
  - Expect push=4'b1011, D_push=16'hFFAB, a single pulse, pkt_cnt+1.
- Fairness:
  - Stimulus: pndng=1111 held constant; all heads addressed to port 0.
  - Expect grant order 0,1,2,3,0; exactly 5 pops over 20 cycles.
- Back-pressure:
  - Stimulus: driver 1 → dest 3; full[3]=1 for 10 cycles.
  - Expect busy held; push=0 while full[3]=1; push=1000 the cycle after full[3] falls.
- Invalid dest:
  - Stimulus: head=16'h07CC with drvrs=4.
  - Expect pop pulse, drop pulse at DECODE, no push, pkt_cnt unchanged.
- Reset mid-DELIVER:
  - Stimulus: reset low while blocked on full.
  - Expect all outputs 0 asynchronously; after release, the first grant goes to port 0.
